// File: rtl/cpu_sysid_pkg.sv
// ============================================================================
// Module  : cpu_sysid_pkg
// Brief   : Register map, CONTROL bit positions and capability-word layout
// Revision: 1.0
// ============================================================================
`default_nettype none

package cpu_sysid_pkg;

    localparam logic [2:0] REG_ID        = 3'd0;
    localparam logic [2:0] REG_TIMESTAMP = 3'd1;
    localparam logic [2:0] REG_VERSION   = 3'd2;
    localparam logic [2:0] REG_SCRATCH   = 3'd3;
    localparam logic [2:0] REG_UPTIME_LO = 3'd4;
    localparam logic [2:0] REG_UPTIME_HI = 3'd5;
    localparam logic [2:0] REG_SECONDS   = 3'd6;
    localparam logic [2:0] REG_CONTROL   = 3'd7;

    localparam int CTRL_CLR_ALL = 0;
    localparam int CTRL_CLR_SEC = 1;

    localparam int CAP_BASE_BIT = 0;
    localparam int CAP_LAT2_BIT = 1;

    function automatic logic [31:0] cap_word(input int read_latency);
        logic [31:0] w;
        w               = '0;
        w[CAP_BASE_BIT] = 1'b1;
        w[CAP_LAT2_BIT] = (read_latency == 2);
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_sysid_timebase.sv
// ============================================================================
// Module  : cpu_sysid_timebase
// Brief   : 64-bit free-running uptime counter plus prescaled seconds counter
// Revision: 1.0
// ============================================================================
`default_nettype none

module cpu_sysid_timebase #(
    parameter int CLOCK_FREQ = 50000000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        clr_all,
    input  logic        clr_sec,
    output logic [63:0] uptime,
    output logic [31:0] seconds
);

    localparam int            PW        = $clog2(CLOCK_FREQ);
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLOCK_FREQ - 1);

    logic [63:0]   r_uptime;
    logic [PW-1:0] r_presc;
    logic [31:0]   r_seconds;

    // A clear loads zero on its edge and therefore wins over any wrap.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_uptime  <= '0;
            r_presc   <= '0;
            r_seconds <= '0;
        end else if (clr_all) begin
            r_uptime  <= '0;
            r_presc   <= '0;
            r_seconds <= '0;
        end else begin
            r_uptime <= r_uptime + 64'd1;
            if (clr_sec) begin
                r_presc   <= '0;
                r_seconds <= '0;
            end else if (r_presc == PRESC_MAX) begin
                r_presc   <= '0;
                r_seconds <= r_seconds + 32'd1;
            end else begin
                r_presc <= r_presc + {{(PW-1){1'b0}}, 1'b1};
            end
        end
    end

    assign uptime  = r_uptime;
    assign seconds = r_seconds;

endmodule

`default_nettype wire

// File: rtl/cpu_sysid_regs.sv
// ============================================================================
// Module  : cpu_sysid_regs
// Brief   : Avalon-MM system ID / scratch / uptime slave with pipelined reads
// Revision: 1.0
// ============================================================================
`default_nettype none

module cpu_sysid_regs
    import cpu_sysid_pkg::*;
#(
    parameter logic [31:0] SYS_ID       = 32'd2,
    parameter logic [31:0] TIMESTAMP    = 32'd1498619909,
    parameter logic [31:0] VERSION      = 32'h0001_0000,
    parameter int          ADDR_W       = 3,
    parameter int          READ_LATENCY = 1,
    parameter int          CLOCK_FREQ   = 50000000
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              readdatavalid
);

    localparam logic [31:0] CAP_WORD = cap_word(READ_LATENCY);

    logic [31:0] w_addr_ext;
    logic        w_in_range;
    logic [2:0]  w_reg;
    logic        w_wr_ctrl;
    logic        w_clr_all;
    logic        w_clr_sec;
    logic        w_rd_lo;
    logic [63:0] w_uptime;
    logic [31:0] w_seconds;
    logic [31:0] w_rdata;

    logic [31:0] r_scratch;
    logic [31:0] r_shadow;
    logic        r_s1_vld;
    logic [31:0] r_s1_data;

    assign w_addr_ext = 32'(address);
    assign w_in_range = (w_addr_ext < 32'd8);
    assign w_reg      = address[2:0];
    assign w_wr_ctrl  = write && w_in_range && (w_reg == REG_CONTROL);
    assign w_clr_all  = w_wr_ctrl && writedata[CTRL_CLR_ALL];
    assign w_clr_sec  = w_wr_ctrl && writedata[CTRL_CLR_SEC];
    assign w_rd_lo    = read && w_in_range && (w_reg == REG_UPTIME_LO);

    cpu_sysid_timebase #(
        .CLOCK_FREQ(CLOCK_FREQ)
    ) u_timebase (
        .clock  (clock),
        .reset_n(reset_n),
        .clr_all(w_clr_all),
        .clr_sec(w_clr_sec),
        .uptime (w_uptime),
        .seconds(w_seconds)
    );

    always_comb begin
        w_rdata = '0;
        if (w_in_range) begin
            case (w_reg)
                REG_ID:        w_rdata = SYS_ID;
                REG_TIMESTAMP: w_rdata = TIMESTAMP;
                REG_VERSION:   w_rdata = VERSION;
                REG_SCRATCH:   w_rdata = r_scratch;
                REG_UPTIME_LO: w_rdata = w_uptime[31:0];
                REG_UPTIME_HI: w_rdata = r_shadow;
                REG_SECONDS:   w_rdata = w_seconds;
                default:       w_rdata = CAP_WORD;
            endcase
        end
    end

    // Shadow tracks the counter cleared by CLR_ALL, so the clear takes priority.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_scratch <= '0;
            r_shadow  <= '0;
        end else begin
            if (write && w_in_range && (w_reg == REG_SCRATCH)) begin
                r_scratch <= writedata;
            end
            if (w_clr_all) begin
                r_shadow <= '0;
            end else if (w_rd_lo) begin
                r_shadow <= w_uptime[63:32];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_vld  <= 1'b0;
            r_s1_data <= '0;
        end else begin
            r_s1_vld <= read;
            if (read) begin
                r_s1_data <= w_rdata;
            end
        end
    end

    generate
        if (READ_LATENCY == 1) begin : g_lat1
            assign readdata      = r_s1_data;
            assign readdatavalid = r_s1_vld;
        end else begin : g_lat2
            logic        r_s2_vld;
            logic [31:0] r_s2_data;

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    r_s2_vld  <= 1'b0;
                    r_s2_data <= '0;
                end else begin
                    r_s2_vld <= r_s1_vld;
                    if (r_s1_vld) begin
                        r_s2_data <= r_s1_data;
                    end
                end
            end

            assign readdata      = r_s2_data;
            assign readdatavalid = r_s2_vld;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_cpu_sysid_regs.sv
// ============================================================================
// Module  : tb_cpu_sysid_regs
// Brief   : Scoreboard bench for cpu_sysid_regs at read latency 1 and 2
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_cpu_sysid_regs;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [3:0]  addr1, addr2;
    logic        rd1, rd2, wr1, wr2;
    logic [31:0] wd1, wd2;
    logic [31:0] rdata1, rdata2;
    logic        rdv1, rdv2;

    always #5 clock = ~clock;

    cpu_sysid_regs #(
        .ADDR_W(4), .READ_LATENCY(1), .CLOCK_FREQ(10)
    ) u_dut1 (
        .clock(clock), .reset_n(reset_n), .address(addr1), .read(rd1),
        .write(wr1), .writedata(wd1), .readdata(rdata1), .readdatavalid(rdv1)
    );

    cpu_sysid_regs #(
        .ADDR_W(4), .READ_LATENCY(2), .CLOCK_FREQ(10)
    ) u_dut2 (
        .clock(clock), .reset_n(reset_n), .address(addr2), .read(rd2),
        .write(wr2), .writedata(wd2), .readdata(rdata2), .readdatavalid(rdv2)
    );

    typedef struct {
        logic [31:0] data;
        int          due;
        string       tag;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    // Reference model of DUT 1 timekeeping: value = base + cycles since base.
    logic [63:0] ub1;
    int          ubc1;
    int          sbc1;
    logic [31:0] shadow1;
    logic [31:0] sc1;
    logic [31:0] last1, last2;

    always @(posedge clock) cyc++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] up1();
        return ub1 + 64'(cyc - ubc1);
    endfunction

    function automatic logic [31:0] sec1();
        return 32'((cyc - sbc1) / 10);
    endfunction

    always @(negedge clock) begin
        exp_t e;
        if (rdv1) begin
            if (q1.size() == 0) begin
                chk("unexp_rdv1", 64'(rdv1), 64'd0);
            end else begin
                e = q1.pop_front();
                chk(e.tag, 64'(rdata1), 64'(e.data));
                chk({e.tag, "_lat"}, 64'(cyc), 64'(e.due));
                last1 = e.data;
            end
        end
        if (rdv2) begin
            if (q2.size() == 0) begin
                chk("unexp_rdv2", 64'(rdv2), 64'd0);
            end else begin
                e = q2.pop_front();
                chk(e.tag, 64'(rdata2), 64'(e.data));
                chk({e.tag, "_lat"}, 64'(cyc), 64'(e.due));
                last2 = e.data;
            end
        end
    end

    task automatic cycle();
        @(posedge clock);
        #1;
        rd1 = 1'b0; wr1 = 1'b0; rd2 = 1'b0; wr2 = 1'b0;
    endtask

    task automatic drive_rd(input int sel, input logic [3:0] a, input logic [31:0] e, input string tag);
        if (sel == 0) begin
            addr1 = a; rd1 = 1'b1;
            q1.push_back('{e, cyc + 1, tag});
        end else begin
            addr2 = a; rd2 = 1'b1;
            q2.push_back('{e, cyc + 2, tag});
        end
    endtask

    task automatic drive_wr(input int sel, input logic [3:0] a, input logic [31:0] d);
        if (sel == 0) begin
            addr1 = a; wr1 = 1'b1; wd1 = d;
            if (a == 4'd3) sc1 = d;
            if (a == 4'd7) begin
                if (d[0]) begin
                    ub1 = '0; ubc1 = cyc + 1; sbc1 = cyc + 1; shadow1 = '0;
                end else if (d[1]) begin
                    sbc1 = cyc + 1;
                end
            end
        end else begin
            addr2 = a; wr2 = 1'b1; wd2 = d;
        end
    endtask

    task automatic rd(input int sel, input logic [3:0] a, input logic [31:0] e, input string tag);
        cycle();
        drive_rd(sel, a, e, tag);
    endtask

    task automatic wr(input int sel, input logic [3:0] a, input logic [31:0] d);
        cycle();
        drive_wr(sel, a, d);
    endtask

    task automatic rd_lo();
        logic [63:0] v;
        cycle();
        v       = up1();
        shadow1 = v[63:32];
        drive_rd(0, 4'd4, v[31:0], "uptime_lo");
    endtask

    task automatic rd_hi();
        cycle();
        drive_rd(0, 4'd5, shadow1, "uptime_hi");
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        rd1 = 1'b0; wr1 = 1'b0; rd2 = 1'b0; wr2 = 1'b0;
        chk("rst_rdata1", 64'(rdata1), 64'd0);
        chk("rst_rdv1", 64'(rdv1), 64'd0);
        chk("rst_rdata2", 64'(rdata2), 64'd0);
        chk("rst_rdv2", 64'(rdv2), 64'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        ub1 = '0; ubc1 = cyc; sbc1 = cyc; shadow1 = '0; sc1 = '0;
    endtask

    initial begin
        logic [63:0] v;
        reset_n = 1'b0;
        addr1 = '0; addr2 = '0; rd1 = 1'b0; rd2 = 1'b0;
        wr1 = 1'b0; wr2 = 1'b0; wd1 = '0; wd2 = '0;
        last1 = '0; last2 = '0;
        do_reset();

        // Identification words back-to-back
        rd(0, 4'd0, 32'd2, "id");
        rd(0, 4'd1, 32'd1498619909, "timestamp");
        rd(0, 4'd2, 32'h0001_0000, "version");
        cycle();

        // Scratch, then a read killed by reset
        wr(0, 4'd3, 32'hA5A5_5A5A);
        rd(0, 4'd3, sc1, "scratch");
        cycle();
        cycle();
        addr1 = 4'd3; rd1 = 1'b1;
        #2;
        do_reset();
        rd(0, 4'd3, sc1, "scratch_after_rst");

        // Seconds after ~35 cycles, then CLR_SEC leaves uptime alone
        repeat (34) cycle();
        cycle();
        drive_rd(0, 4'd6, sec1(), "seconds");
        wr(0, 4'd7, 32'h2);
        cycle();
        drive_rd(0, 4'd6, sec1(), "seconds_clr");
        rd_lo();
        rd_hi();

        // CLR_ALL clears uptime, shadow and seconds
        wr(0, 4'd7, 32'h1);
        rd_hi();
        rd_lo();
        cycle();
        drive_rd(0, 4'd6, sec1(), "seconds_clrall");

        // Coherent LO/HI across the 32-bit carry
        cycle();
        u_dut1.u_timebase.r_uptime = 64'h0000_0000_FFFF_FFFE;
        ub1 = 64'h0000_0000_FFFF_FFFE; ubc1 = cyc;
        v = up1();
        shadow1 = v[63:32];
        drive_rd(0, 4'd4, v[31:0], "uptime_lo_carry");
        repeat (5) cycle();
        rd_hi();
        rd_lo();
        rd_hi();

        // RO writes, out-of-range accesses, capability
        wr(0, 4'd0, 32'hFFFF_FFFF);
        rd(0, 4'd0, 32'd2, "id_ro");
        wr(0, 4'd11, 32'hDEAD_BEEF);
        rd(0, 4'd3, sc1, "scratch_alias");
        rd(0, 4'd12, 32'd0, "unmapped1");
        rd(0, 4'd7, 32'h1, "cap1");

        // Same-cycle read and write of SCRATCH
        wr(0, 4'd3, 32'h11);
        cycle();
        drive_rd(0, 4'd3, sc1, "scratch_rw_old");
        drive_wr(0, 4'd3, 32'h22);
        rd(0, 4'd3, sc1, "scratch_rw_new");

        // Read latency 2 instance
        rd(1, 4'd7, 32'h3, "cap2");
        rd(1, 4'd9, 32'd0, "unmapped2");
        rd(1, 4'd1, 32'd1498619909, "timestamp2");
        cycle();

        for (int i = 0; i < 10 && (q1.size() != 0 || q2.size() != 0); i++) cycle();
        chk("drain1", 64'(q1.size()), 64'd0);
        chk("drain2", 64'(q2.size()), 64'd0);
        cycle();
        chk("hold1", 64'(rdata1), 64'(last1));
        chk("hold2", 64'(rdata2), 64'(last2));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
